disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, blanked
// digit stepping with a prescaled tick, optional leading-zero suppression.
module disp_scan_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DIV         = 1000,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lz_suppress,
    output logic [3:0]            val_out,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  pending,
    output logic                  load_ack,
    output logic                  frame_done
);

    localparam int unsigned CW   = $clog2(DIV);
    localparam int unsigned TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned IW   = $clog2(DIGITS);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;
    logic [DIGITS-1:0]     digit_en_n_q, digit_en_n_d;
    logic [3:0]            val_out_q, val_out_d;

    logic                  tick;
    logic                  tick_last;
    logic                  frame_end;
    logic                  swap;
    logic                  zero_run;
    logic [DIGITS-1:0]     suppress;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        tick         = 1'b0;
        tick_last    = 1'b0;
        frame_end    = 1'b0;
        swap         = 1'b0;

        if (enable) begin
            tick  = (cnt_q == CW'(DIV - 1));
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                tick_last = (state_q == BLANK) ? (tcnt_q == TW'(BLANK_TICKS - 1))
                                               : (tcnt_q == TW'(ON_TICKS - 1));
                if (tick_last) begin
                    tcnt_d = '0;
                    if (state_q == BLANK) begin
                        state_d = SHOW;
                    end else begin
                        state_d = BLANK;
                        if (idx_q == IW'(DIGITS - 1)) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d   = '0;
            tcnt_d  = '0;
            state_d = BLANK;
            idx_d   = '0;
        end

        // While disabled there is no frame boundary, so a pending word swaps immediately.
        swap = pending_q & (frame_end | ~enable);
        if (swap) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
        if (load) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
        end
        frame_done_d = frame_end;

        zero_run = 1'b1;
        suppress = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run & (active_d[4*(DIGITS-1-k) +: 4] == 4'd0);
            if (k != DIGITS - 1) begin
                suppress[DIGITS-1-k] = lz_suppress & zero_run;
            end
        end

        digit_en_n_d = '1;
        if (state_d == SHOW && !suppress[idx_d]) begin
            digit_en_n_d[idx_d] = 1'b0;
        end

        // Refreshing throughout BLANK equals loading on entry: active and idx only move then.
        val_out_d = (state_d == BLANK) ? active_d[4*idx_d +: 4] : val_out_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            digit_en_n_q <= '1;
            val_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            digit_en_n_q <= digit_en_n_d;
            val_out_q    <= val_out_d;
        end
    end

    assign val_out    = val_out_q;
    assign digit_en_n = digit_en_n_q;
    assign pending    = pending_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl (4 digits, 4-cycle tick, 2 on / 1 blank tick):
// loaded words are queued as expected frames and checked when acknowledged.
module tb_disp_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_suppress;
    logic [3:0]  val_out;
    logic [3:0]  digit_en_n;
    logic        pending;
    logic        load_ack;
    logic        frame_done;

    disp_scan_ctrl #(
        .DIGITS(4),
        .DIV(4),
        .ON_TICKS(2),
        .BLANK_TICKS(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .load(load),
        .bcd_in(bcd_in),
        .lz_suppress(lz_suppress),
        .val_out(val_out),
        .digit_en_n(digit_en_n),
        .pending(pending),
        .load_ack(load_ack),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // en holds the expected digit_en_n while digit i is in SHOW, nibble i.
    typedef struct packed {
        logic [15:0] bcd;
        logic        lz;
        logic [15:0] en;
        logic        at_frame;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[7];
    bit   mon_busy = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [15:0] b, input logic l,
                                input logic [15:0] e, input logic f);
        vec_t v;
        v.bcd = b;
        v.lz = l;
        v.en = e;
        v.at_frame = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fd(input string nm, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (frame_done) return;
        end
        timeout(nm);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && !mon_busy) begin
                step();
                return;
            end
        end
        timeout("scoreboard_drain");
        step();
    endtask

    // r counts negedges after the frame_done/load_ack cycle (r = 0).
    task automatic check_frame(input vec_t e);
        int extra = 0;
        for (int r = 1; r < 48; r++) begin
            @(negedge clock);
            if (load_ack) extra++;
            for (int i = 0; i < 4; i++) begin
                if (r == 12*i + 3)
                    chk($sformatf("blank_d%0d_%0h", i, e.bcd), 32'({digit_en_n, val_out}),
                        32'({4'hF, e.bcd[4*i +: 4]}));
                if (r == 12*i + 4 || r == 12*i + 11)
                    chk($sformatf("show_d%0d_r%0d_%0h", i, r, e.bcd), 32'({digit_en_n, val_out}),
                        32'({e.en[4*i +: 4], e.bcd[4*i +: 4]}));
            end
        end
        chk("single_ack_in_frame", 32'(extra), 32'(0));
    endtask

    initial begin : monitor
        vec_t e;
        forever begin
            @(negedge clock);
            if (reset_n && load_ack) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_load_ack: got 1, want 0");
                end else begin
                    e = sb.pop_front();
                    chk("ack_at_frame_end", 32'(frame_done), 32'(e.at_frame));
                    if (e.at_frame) begin
                        mon_busy = 1'b1;
                        check_frame(e);
                        mon_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        int t0;
        tbl[0] = mk(16'h0050, 1'b1, 16'hFFDE, 1'b1);
        tbl[1] = mk(16'h0050, 1'b0, 16'h7BDE, 1'b1);
        tbl[2] = mk(16'h0000, 1'b1, 16'hFFFE, 1'b1);
        tbl[3] = mk(16'h9A05, 1'b1, 16'h7BDE, 1'b1);
        tbl[4] = mk(16'h00F0, 1'b1, 16'hFFDE, 1'b1);
        tbl[5] = mk(16'h0700, 1'b1, 16'hFBDE, 1'b1);
        tbl[6] = mk(16'h0000, 1'b0, 16'h7BDE, 1'b1);

        reset_n = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        bcd_in = '0;
        lz_suppress = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_digit_en_n", 32'(digit_en_n), 32'(4'hF));
        chk("rst_val_out", 32'(val_out), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_load_ack", 32'(load_ack), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));

        // First load right at reset release: acknowledged at end of frame 1.
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        enable = 1'b1;
        t0 = cyc;
        sb.push_back(mk(16'h1234, 1'b0, 16'h7BDE, 1'b1));
        do_load(16'h1234);
        @(negedge clock);
        chk("pending_after_load", 32'(pending), 32'(1));
        wait_fd("first_frame_done", 100);
        chk("first_frame_len", 32'(cyc - t0), 32'(48));
        chk("first_load_ack", 32'(load_ack), 32'(1));
        t0 = cyc;
        wait_fd("second_frame_done", 100);
        chk("frame_period", 32'(cyc - t0), 32'(48));

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            lz_suppress = tbl[i].lz;
            do_load(tbl[i].bcd);
            sb.push_back(tbl[i]);
        end

        // Overwrite while pending: one ack, only the second word shown.
        wait_idle();
        lz_suppress = 1'b0;
        do_load(16'hAAAA);
        step();
        sb.push_back(mk(16'h9876, 1'b0, 16'h7BDE, 1'b1));
        do_load(16'h9876);

        // Load in the frame-end tick cycle while another word is pending.
        wait_idle();
        wait_fd("sync_frame_coincident", 100);
        step();
        sb.push_back(mk(16'h1111, 1'b0, 16'h7BDE, 1'b1));
        do_load(16'h1111);
        repeat (45) step();
        sb.push_back(mk(16'h4321, 1'b0, 16'h7BDE, 1'b1));
        do_load(16'h4321);
        @(negedge clock);
        chk("coincident_ack", 32'({frame_done, load_ack}), 32'(2'b11));
        chk("coincident_pending", 32'(pending), 32'(1));

        // Disable mid-SHOW of digit 2 with a pending word.
        wait_idle();
        wait_fd("sync_frame_disable", 100);
        step();
        sb.push_back(mk(16'h5678, 1'b0, 16'hFFFF, 1'b0));
        do_load(16'h5678);
        repeat (28) step();
        enable = 1'b0;
        @(negedge clock);
        chk("pre_disable_d2_lit", 32'({digit_en_n, val_out}), 32'({4'b1011, 4'd3}));
        @(negedge clock);
        chk("disable_dark", 32'(digit_en_n), 32'(4'hF));
        chk("disable_swap", 32'({load_ack, pending, frame_done}), 32'(3'b100));
        step();
        sb.push_back(mk(16'h0003, 1'b0, 16'hFFFF, 1'b0));
        do_load(16'h0003);
        @(negedge clock);
        chk("disabled_load_pending", 32'(pending), 32'(1));
        @(negedge clock);
        chk("disabled_load_swap", 32'({load_ack, pending}), 32'(2'b10));
        repeat (5) step();
        @(negedge clock);
        chk("disabled_quiet", 32'({digit_en_n, frame_done}), 32'(5'b11110));
        step();
        enable = 1'b1;
        repeat (3) step();
        @(negedge clock);
        chk("reenable_blank", 32'({digit_en_n, val_out}), 32'({4'hF, 4'd3}));
        @(negedge clock);
        chk("reenable_d0_lit", 32'({digit_en_n, val_out}), 32'({4'b1110, 4'd3}));

        // Asynchronous reset mid-frame discards a pending load.
        step();
        do_load(16'h2222);
        chk("pre_reset_state", 32'({digit_en_n, pending}), 32'(5'b11101));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({digit_en_n, val_out, load_ack, frame_done}),
            32'({4'hF, 4'h0, 2'b00}));
        chk("async_rst_pending", 32'(pending), 32'(0));
        repeat (2) step();
        reset_n = 1'b1;
        wait_fd("post_reset_frame", 100);
        chk("post_reset_no_ack", 32'({load_ack, pending}), 32'(2'b00));
        chk("post_reset_active_cleared", 32'(val_out), 32'(0));

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
